// File: rtl/apb_reg_responder.sv
// -----------------------------------------------------------------------------
// apb_reg_responder
//
// APB-style register target for the firmware-visible control registers of the
// MIPI control domain. Holds NREGS read/write control words, a live status
// word at index NREGS and a constant ID word at index NREGS+1. Every transfer
// is stretched by WAIT_CYCLES wait states and completes with a single-cycle
// pready pulse. Out-of-range accesses and transfers abandoned mid-wait raise a
// sticky error flag that firmware clears by writing 1 to bit 0 of the status
// index.
//
// Ports
//   i_clk        single clock for all logic
//   i_rst        asynchronous, active-high reset
//   i_psel       transfer request, held high by the master until pready
//   i_pwrite     1 = write, 0 = read
//   i_paddr      byte address; bits [1:0] are ignored
//   i_pwdata     write data
//   o_prdata     read data, non-zero only during the pready cycle of a read
//   o_pready     one-cycle completion pulse
//   i_status_in  live status word, readable at index NREGS
//   o_reg_q      flattened control registers, reg i = bits [32i+31:32i]
//   o_wr_strobe  one-cycle pulse on the register being written
//   o_err_flag   sticky error flag
//
// States
//   ST_IDLE | waiting for psel; captures the request when it arrives
//   ST_WAIT | counting wait states; a dropped psel aborts the transfer
//   ST_RESP | pready high; read data driven, write already committed
//   ST_TURN | psel ignored for one cycle so the master can release it
// -----------------------------------------------------------------------------
module apb_reg_responder #(
  parameter int          ADDR_W      = 20,
  parameter int          NREGS       = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h4D495049
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_psel,
  input  logic                  i_pwrite,
  input  logic [ADDR_W-1:0]     i_paddr,
  input  logic [31:0]           i_pwdata,
  output logic [31:0]           o_prdata,
  output logic                  o_pready,
  input  logic [31:0]           i_status_in,
  output logic [NREGS*32-1:0]   o_reg_q,
  output logic [NREGS-1:0]      o_wr_strobe,
  output logic                  o_err_flag
);

  localparam int               IDX_W      = ADDR_W - 2;
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NREGS);
  localparam logic [IDX_W-1:0] ID_IDX     = IDX_W'(NREGS + 1);
  // The counter is loaded with WAIT_CYCLES-1 so that the WAIT state lasts
  // exactly WAIT_CYCLES cycles; with no wait states it is never used.
  localparam logic [3:0]       CNT_INIT   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_TURN = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [3:0]              r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_write;
  logic [31:0]             r_wdata;
  logic [NREGS-1:0][31:0]  r_regs;
  logic [NREGS-1:0]        r_wr_strobe;
  logic                    r_err;

  logic                    w_start;
  logic                    w_enter_resp;
  logic                    w_abort;
  logic [IDX_W-1:0]        w_dec_idx;
  logic                    w_dec_write;
  logic [31:0]             w_dec_wdata;
  logic [NREGS-1:0]        w_sel;
  logic                    w_bad_idx;
  logic                    w_err_clr;
  logic [31:0]             w_rdata;
  logic                    w_unused_addr;

  // Byte-lane bits of the address carry no meaning for word registers.
  assign w_unused_addr = ^i_paddr[1:0];

  assign w_start = (r_state == ST_IDLE) && i_psel;

  // With zero wait states the commit edge is the capture edge itself, so the
  // decode must look at the live bus in IDLE and at the captured copy
  // otherwise.
  assign w_dec_idx   = (r_state == ST_IDLE) ? i_paddr[ADDR_W-1:2] : r_idx;
  assign w_dec_write = (r_state == ST_IDLE) ? i_pwrite : r_write;
  assign w_dec_wdata = (r_state == ST_IDLE) ? i_pwdata : r_wdata;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_sel[i] = (w_dec_idx == IDX_W'(i));
    end
  end

  assign w_bad_idx = (w_dec_idx > ID_IDX);
  assign w_err_clr = w_enter_resp && w_dec_write && (w_dec_idx == STATUS_IDX) && w_dec_wdata[0];

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_enter_resp = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_psel) begin
          if (WAIT_CYCLES == 0) begin
            w_next       = ST_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!i_psel) begin
          w_next  = ST_IDLE;
          w_abort = 1'b1;
        end else if (r_cnt == 4'd0) begin
          w_next       = ST_RESP;
          w_enter_resp = 1'b1;
        end
      end
      ST_RESP: w_next = ST_TURN;
      ST_TURN: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture and wait-state down-counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_cnt   <= CNT_INIT;
      r_idx   <= i_paddr[ADDR_W-1:2];
      r_write <= i_pwrite;
      r_wdata <= i_pwdata;
    end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank and write strobes, committed on the edge entering RESP
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_regs      <= '0;
      r_wr_strobe <= '0;
    end else begin
      r_wr_strobe <= '0;
      if (w_enter_resp && w_dec_write) begin
        r_wr_strobe <= w_sel;
        for (int i = 0; i < NREGS; i++) begin
          if (w_sel[i]) begin
            r_regs[i] <= w_dec_wdata;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flag; a new error takes priority over a clear on the same edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_abort || (w_enter_resp && w_bad_idx)) begin
      r_err <= 1'b1;
    end else if (w_err_clr) begin
      r_err <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data: decoded from the captured index; status is the live input
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    if (r_idx == STATUS_IDX) begin
      w_rdata = i_status_in;
    end else if (r_idx == ID_IDX) begin
      w_rdata = ID_VALUE;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (r_idx == IDX_W'(i)) begin
          w_rdata = r_regs[i];
        end
      end
    end
  end

  // pready and prdata derive from the state register so that an asserted
  // reset removes them immediately.
  assign o_pready    = (r_state == ST_RESP);
  assign o_prdata    = (o_pready && !r_write) ? w_rdata : 32'd0;
  assign o_reg_q     = r_regs;
  assign o_wr_strobe = r_wr_strobe;
  assign o_err_flag  = r_err;

endmodule

// File: tb/tb_apb_reg_responder.sv
// -----------------------------------------------------------------------------
// tb_apb_reg_responder
//
// Four instances of the responder with different wait-state counts share the
// bus signals but each has its own psel. Transfers push an entry to a
// scoreboard; a monitor pops it on pready and compares read data, latency,
// write strobes, register contents and the error flag against a small model.
// Instance map: 0 -> 1 wait, 1 -> 0 waits, 2 -> 15 waits, 3 -> 4 waits.
// -----------------------------------------------------------------------------
module tb_apb_reg_responder;

  localparam logic [31:0] ID_VAL = 32'h4D495049;

  function automatic int wc(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      2:       return 15;
      default: return 4;
    endcase
  endfunction

  logic        clk;
  logic        rst;
  logic        psel [4];
  logic        pwrite;
  logic [19:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] status_in;
  logic [31:0] prdata [4];
  logic        pready [4];
  logic [511:0] reg_q [4];
  logic [15:0] wr_strobe [4];
  logic        err_flag [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    apb_reg_responder #(
      .ADDR_W      (20),
      .NREGS       (16),
      .WAIT_CYCLES (wc(g)),
      .ID_VALUE    (ID_VAL)
    ) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_psel      (psel[g]),
      .i_pwrite    (pwrite),
      .i_paddr     (paddr),
      .i_pwdata    (pwdata),
      .o_prdata    (prdata[g]),
      .o_pready    (pready[g]),
      .i_status_in (status_in),
      .o_reg_q     (reg_q[g]),
      .o_wr_strobe (wr_strobe[g]),
      .o_err_flag  (err_flag[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic chk_val(input string tag, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model
  logic [31:0] mdl [4][16];
  logic        emdl [4];

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      emdl[d] = 1'b0;
      for (int i = 0; i < 16; i++) mdl[d][i] = 32'd0;
    end
  endtask

  function automatic logic [511:0] pack(input int d);
    logic [511:0] p;
    p = '0;
    for (int i = 0; i < 16; i++) p[i*32 +: 32] = mdl[d][i];
    return p;
  endfunction

  function automatic logic [31:0] read_model(input int d, input int idx);
    if (idx < 16)  return mdl[d][idx];
    if (idx == 16) return status_in;
    if (idx == 17) return ID_VAL;
    return 32'd0;
  endfunction

  typedef struct {
    int          dut;
    bit          wr;
    logic [19:0] addr;
    logic [31:0] wdata;
    int          start;
    int          lat;
  } item_t;

  item_t sb[$];

  // Monitor: every cycle, for every instance
  item_t       it;
  int          idx;
  logic [15:0] exp_strb;

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 4; d++) begin
        if (pready[d]) begin
          if (sb.size() == 0 || sb[0].dut != d) begin
            chk_val("spurious_pready", 1, 0);
          end else begin
            it  = sb.pop_front();
            idx = int'(it.addr[19:2]);
            chk_val("latency", cyc - it.start + 1, it.lat);
            if (it.wr) begin
              exp_strb = '0;
              if (idx < 16) begin
                mdl[d][idx]   = it.wdata;
                exp_strb[idx] = 1'b1;
              end else if (idx == 16) begin
                if (it.wdata[0]) emdl[d] = 1'b0;
              end else if (idx > 17) begin
                emdl[d] = 1'b1;
              end
              chk_val("wr_strobe", wr_strobe[d], exp_strb);
              chk_val("reg_q", reg_q[d], pack(d));
            end else begin
              if (idx > 17) emdl[d] = 1'b1;
              chk_val("prdata", prdata[d], read_model(d, idx));
            end
            chk_val("err_flag", err_flag[d], emdl[d]);
          end
        end else begin
          chk_val("prdata_idle", prdata[d], 0);
          chk_val("strobe_idle", wr_strobe[d], 0);
        end
      end
    end
  end

  // One transfer on instance d. With hold set, psel stays high through TURN
  // and the next call starts the following transfer back-to-back.
  task automatic xfer(input int d, input bit wr, input logic [19:0] a,
                      input logic [31:0] wd, input bit hold);
    bit seen;
    @(posedge clk); #1;
    psel[d] = 1'b1;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    sb.push_back('{dut: d, wr: wr, addr: a, wdata: wd, start: cyc + 1, lat: wc(d) + 1});
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (pready[d]) seen = 1'b1;
    end
    chk_val("pready_timeout", seen, 1);
    if (!seen) sb.delete();
    if (hold) begin
      @(posedge clk);
    end else begin
      @(posedge clk); #1;
      psel[d] = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    pwrite    = 1'b0;
    paddr     = '0;
    pwdata    = '0;
    status_in = '0;
    for (int d = 0; d < 4; d++) psel[d] = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_pready", pready[0], 0);
    chk_val("rst_prdata", prdata[0], 0);
    chk_val("rst_strobe", wr_strobe[0], 0);
    chk_val("rst_err", err_flag[0], 0);
    chk_val("rst_reg_q", reg_q[0], 0);
    @(negedge clk);
    rst = 1'b0;

    // Write, read back, ID, status
    xfer(0, 1'b1, 20'h00008, 32'hA5A55A5A, 1'b0);
    xfer(0, 1'b0, 20'h00008, 32'h0, 1'b0);
    xfer(0, 1'b0, 20'h00044, 32'h0, 1'b0);
    status_in = 32'h12345678;
    xfer(0, 1'b0, 20'h00040, 32'h0, 1'b0);
    xfer(0, 1'b1, 20'h00040, 32'h0, 1'b0);
    chk_val("err_after_status_wr0", err_flag[0], 0);

    // Out-of-range write sets the flag, status write of 1 clears it
    xfer(0, 1'b1, 20'h00100, 32'hFFFFFFFF, 1'b0);
    chk_val("err_after_bad_wr", err_flag[0], 1);
    xfer(0, 1'b1, 20'h00040, 32'h00000001, 1'b0);
    chk_val("err_cleared", err_flag[0], 0);

    // Zero and fifteen wait states, back-to-back reads through TURN
    for (int d = 1; d <= 2; d++) begin
      for (int i = 0; i < 4; i++) xfer(d, 1'b1, 20'(i * 4), $urandom, 1'b0);
      for (int i = 0; i < 4; i++) xfer(d, 1'b0, 20'(i * 4), 32'h0, (i < 3));
      xfer(d, 1'b0, 20'h00044, 32'h0, 1'b1);
      xfer(d, 1'b0, 20'h00008, 32'h0, 1'b0);
    end

    // Early abort during WAIT
    @(posedge clk); #1;
    psel[3] = 1'b1;
    pwrite  = 1'b1;
    paddr   = 20'h00004;
    pwdata  = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1;
    psel[3] = 1'b0;
    emdl[3] = 1'b1;
    repeat (8) @(negedge clk);
    chk_val("abort_err", err_flag[3], 1);
    chk_val("abort_reg_q", reg_q[3], pack(3));

    // Reset in the middle of a write's wait phase
    xfer(3, 1'b1, 20'h00000, 32'h5555AAAA, 1'b0);
    @(posedge clk); #1;
    psel[3] = 1'b1;
    pwrite  = 1'b1;
    paddr   = 20'h00000;
    pwdata  = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk_val("midrst_pready", pready[3], 0);
    chk_val("midrst_reg0", reg_q[3][31:0], 0);
    chk_val("midrst_strobe", wr_strobe[3], 0);
    @(negedge clk);
    psel[3] = 1'b0;
    rst     = 1'b0;
    xfer(3, 1'b0, 20'h00000, 32'h0, 1'b0);

    repeat (4) @(negedge clk);
    chk_val("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
